// File: rtl/ssp_tx_dma_ctrl_pkg.sv
// Shared SSP constants and DMA controller state encoding.
// Used by the Tx DMA controller and its free-space helper.
package ssp_tx_dma_ctrl_pkg;

  localparam int SSP_TXF_DEPTH = 8;
  localparam int SSP_DMA_BURST = 4;
  localparam int SSP_LVL_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CLRW = 2'd2
  } dma_state_e;

endpackage

// File: rtl/ssp_dma_free_calc.sv
// FIFO free-space computation with saturation and threshold compares.
// Shared by the Tx and Rx DMA request controllers.
module ssp_dma_free_calc
  import ssp_tx_dma_ctrl_pkg::*;
#(
  parameter int DEPTH  = SSP_TXF_DEPTH,
  parameter int THRESH = SSP_DMA_BURST
) (
  input  logic [SSP_LVL_W-1:0] level,
  input  logic                 pend_wr,
  output logic [SSP_LVL_W:0]   free,
  output logic                 ge_one,
  output logic                 ge_thresh
);

  localparam logic [SSP_LVL_W:0] DEPTH_W =
    (SSP_LVL_W+1)'(DEPTH);
  localparam logic [SSP_LVL_W:0] THR_W =
    (SSP_LVL_W+1)'(THRESH);

  logic [SSP_LVL_W:0] occ;

  // Levels above DEPTH land in the saturating branch as full.
  assign occ = {1'b0, level}
             + {{SSP_LVL_W{1'b0}}, pend_wr};

  assign free = (occ >= DEPTH_W) ? '0
              : DEPTH_W - occ;

  assign ge_one    = (free != '0);
  assign ge_thresh = (free >= THR_W);

endmodule

// File: rtl/ssp_tx_dma_ctrl.sv
// SSP Tx DMA request controller (single/burst requests, CLR handshake).
// Burst requests only when SSP_TX_DMA_BURST_EN is defined.
module ssp_tx_dma_ctrl
  import ssp_tx_dma_ctrl_pkg::*;
#(
  parameter int DEPTH = SSP_TXF_DEPTH,
  parameter int BURST = SSP_DMA_BURST
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 TXDMAE,
  input  logic [SSP_LVL_W-1:0] TxFLevel,
  input  logic                 SSPDRWr,
  input  logic                 SSPTXDMACLR,
  output logic                 SSPTXDMASREQ,
  output logic                 SSPTXDMABREQ,
  output logic                 TxDmaBusy
);

  dma_state_e         state;
  logic               pend_wr;
  logic               sreq;
  logic               breq;
  logic               busy;
  logic               ge_one;
  logic               ge_burst;
  logic               breq_load;
  logic [SSP_LVL_W:0] unused_free;

  ssp_dma_free_calc #(
    .DEPTH  (DEPTH),
    .THRESH (BURST)
  ) u_free (
    .level     (TxFLevel),
    .pend_wr   (pend_wr),
    .free      (unused_free),
    .ge_one    (ge_one),
    .ge_thresh (ge_burst)
  );

`ifdef SSP_TX_DMA_BURST_EN
  assign breq_load = ge_burst;
`else
  logic unused_burst;
  assign unused_burst = ge_burst;
  assign breq_load    = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      pend_wr <= 1'b0;
      sreq    <= 1'b0;
      breq    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pend_wr <= SSPDRWr;
      unique case (state)
        IDLE: begin
          if (TXDMAE && !SSPTXDMACLR && ge_one) begin
            state <= REQ;
            sreq  <= 1'b1;
            breq  <= breq_load;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (SSPTXDMACLR) begin
            state <= CLRW;
            sreq  <= 1'b0;
            breq  <= 1'b0;
          end else if (!TXDMAE) begin
            state <= IDLE;
            sreq  <= 1'b0;
            breq  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        CLRW: begin
          if (!SSPTXDMACLR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          sreq  <= 1'b0;
          breq  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign SSPTXDMASREQ = sreq;
  assign SSPTXDMABREQ = breq;
  assign TxDmaBusy    = busy;

endmodule

// File: tb/tb_ssp_tx_dma_ctrl.sv
// Directed scoreboard bench for ssp_tx_dma_ctrl.
// Burst expectations follow SSP_TX_DMA_BURST_EN.
module tb_ssp_tx_dma_ctrl;

`ifdef SSP_TX_DMA_BURST_EN
  localparam logic BE = 1'b1;
`else
  localparam logic BE = 1'b0;
`endif

  logic       PCLK;
  logic       PRESETn;
  logic       TXDMAE;
  logic [3:0] TxFLevel;
  logic       SSPDRWr;
  logic       SSPTXDMACLR;
  logic       SSPTXDMASREQ;
  logic       SSPTXDMABREQ;
  logic       TxDmaBusy;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  ssp_tx_dma_ctrl dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .TXDMAE       (TXDMAE),
    .TxFLevel     (TxFLevel),
    .SSPDRWr      (SSPDRWr),
    .SSPTXDMACLR  (SSPTXDMACLR),
    .SSPTXDMASREQ (SSPTXDMASREQ),
    .SSPTXDMABREQ (SSPTXDMABREQ),
    .TxDmaBusy    (TxDmaBusy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic expect_out(input logic [2:0] e,
                            input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check();
    logic [2:0] e;
    logic [2:0] o;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {SSPTXDMASREQ, SSPTXDMABREQ, TxDmaBusy};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: sreq/breq/busy got %b want %b",
             t, o, e);
    end
  endtask

  task automatic step(input logic       en,
                      input logic [3:0] lvl,
                      input logic       wr,
                      input logic       clr,
                      input logic [2:0] e,
                      input string      t);
    TXDMAE      = en;
    TxFLevel    = lvl;
    SSPDRWr     = wr;
    SSPTXDMACLR = clr;
    expect_out(e, t);
    @(posedge PCLK);
    #1;
    check();
  endtask

  initial begin
    PRESETn     = 1'b0;
    TXDMAE      = 1'b1;
    TxFLevel    = 4'd0;
    SSPDRWr     = 1'b0;
    SSPTXDMACLR = 1'b0;
    #12;
    expect_out(3'b000, "reset");
    check();

    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    step(1, 0, 0, 0, {1'b1, BE, 1'b1}, "rst_rel_req");

    step(1, 0, 0, 1, 3'b001, "clr1");
    step(1, 0, 0, 1, 3'b001, "clr2");
    step(1, 0, 0, 1, 3'b001, "clr3");
    step(1, 0, 0, 0, 3'b000, "clrw_exit");
    step(1, 0, 0, 0, {1'b1, BE, 1'b1}, "rearm");

    step(0, 0, 0, 0, 3'b000, "dmae_drop");
    step(0, 0, 0, 0, 3'b000, "dmae_off");

    step(1, 6, 0, 0, 3'b101, "lvl6_single");
    step(1, 6, 0, 1, 3'b001, "lvl6_clr");
    step(1, 8, 0, 0, 3'b000, "lvl8_exit");
    step(1, 8, 0, 0, 3'b000, "lvl8_full");
    step(1, 4, 0, 0, {1'b1, BE, 1'b1}, "lvl4_burst");

    step(1, 8, 0, 0, {1'b1, BE, 1'b1}, "type_fixed");
    step(1, 8, 1, 1, 3'b001, "clr_wins_wr");
    step(1, 8, 0, 0, 3'b000, "clrw_exit2");

    step(0, 7, 1, 0, 3'b000, "pend_wr");
    step(1, 7, 0, 0, 3'b000, "pend_blocks");
    step(1, 8, 0, 0, 3'b000, "lvl8_after_wr");
    step(1, 15, 0, 0, 3'b000, "lvl_overflow");
    step(1, 5, 0, 0, 3'b101, "lvl5_single");

    step(0, 5, 0, 1, 3'b001, "dmae_clr_clrw");
    step(1, 0, 0, 1, 3'b001, "clr_hold1");
    step(1, 0, 0, 1, 3'b001, "clr_hold2");
    step(1, 0, 0, 0, 3'b000, "clr_hold_exit");

    step(1, 0, 0, 1, 3'b000, "idle_clr_block");
    step(1, 0, 0, 0, {1'b1, BE, 1'b1}, "idle_clr_rel");

    #4;
    PRESETn = 1'b0;
    #1;
    expect_out(3'b000, "async_reset");
    check();
    #1;
    PRESETn = 1'b1;
    step(1, 0, 0, 0, {1'b1, BE, 1'b1}, "post_reset_req");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
